// File: rtl/oserdes_tx_framer.sv
// oserdes_tx_framer
//  Transmit framer for a chip-to-chip link. It runs in the clkdiv (word-rate) domain and drives
//  the parallel word into the far-end OSERDESE2. q[7] is the first bit on the wire.
//  Once lock is seen, it sends a burst of TRAIN_PATTERN words so the far-end bitslip aligner
//  can lock. It then streams user words from a small FIFO, and sends IDLE_WORD whenever the
//  FIFO is empty.
//
// Ports
//  clkdiv      word-rate clock
//  rst         asynchronous active-high reset
//  locked_in   MMCM locked (asynchronous, synchronised here)
//  retrain     1-cycle request for a new training burst
//  s_data      user word
//  s_valid     user word valid
//  s_ready     FIFO can accept a word
//  q           registered parallel word to the OSERDES
//  training    high while training words are on q
//  link_up     high while the framer streams user or idle words
//  fifo_level  number of words held in the FIFO
module oserdes_tx_framer #(
    parameter int unsigned TRAIN_WORDS   = 64,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h0A,
    parameter logic [7:0]  IDLE_WORD     = 8'hFF,
    parameter int unsigned FIFO_AW       = 3
) (
    input  logic               clkdiv,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               retrain,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [7:0]         q,
    output logic               training,
    output logic               link_up,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = $clog2(TRAIN_WORDS + 1);

    typedef enum logic [1:0] {StWaitLock, StTrain, StRun} state_e;

    state_e             state_q;
    logic [1:0]         sync_q;
    logic               lock_s;
    logic [CW-1:0]      cnt_q;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               train_done;
    logic               run_next;

    assign lock_s     = sync_q[1];
    assign full       = (level_q == (FIFO_AW + 1)'(DEPTH));
    assign empty      = (level_q == '0);
    assign s_ready    = (state_q != StWaitLock) && !full;
    assign push       = s_valid && s_ready;
    assign fifo_level = level_q;

    // cnt_q holds the number of pattern words already loaded into q in this burst.
    assign train_done = (cnt_q == CW'(TRAIN_WORDS));

    // The next state is RUN: lock held, no retrain, and either already running or the
    // last training word has been sent. Lock loss and retrain both override this.
    assign run_next = lock_s && !retrain &&
                      ((state_q == StRun) || ((state_q == StTrain) && train_done));
    assign pop      = run_next && !empty;

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked_in};
        end
    end

    // FSM; q, training and link_up are registered from the next state.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state_q  <= StWaitLock;
            q        <= IDLE_WORD;
            training <= 1'b0;
            link_up  <= 1'b0;
            cnt_q    <= '0;
        end else if (!lock_s) begin
            state_q  <= StWaitLock;
            q        <= IDLE_WORD;
            training <= 1'b0;
            link_up  <= 1'b0;
            cnt_q    <= '0;
        end else if (run_next) begin
            state_q  <= StRun;
            q        <= empty ? IDLE_WORD : mem_q[rd_ptr_q];
            training <= 1'b0;
            link_up  <= 1'b1;
        end else begin
            // Entering TRAIN, continuing it, or restarting it on retrain. The word loaded
            // on entry or restart is word 1 of the new burst.
            state_q  <= StTrain;
            q        <= TRAIN_PATTERN;
            training <= 1'b1;
            link_up  <= 1'b0;
            if ((state_q == StTrain) && !retrain) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= CW'(1);
            end
        end
    end

    always_ff @(posedge clkdiv) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (!lock_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
                2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_oserdes_tx_framer.sv
module tb_oserdes_tx_framer;

    logic       clkdiv;
    logic       rst;
    logic       locked_in;
    logic       retrain;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] q;
    logic       training;
    logic       link_up;
    logic [3:0] fifo_level;

    int n_pass  = 0;
    int n_total = 0;

    oserdes_tx_framer dut (
        .clkdiv     (clkdiv),
        .rst        (rst),
        .locked_in  (locked_in),
        .retrain    (retrain),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .q          (q),
        .training   (training),
        .link_up    (link_up),
        .fifo_level (fifo_level)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    task automatic tick();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // 64 training words aligned with training=1, then idle with link_up=1.
    task automatic expect_burst(input string tag);
        for (int i = 0; i < 64; i++) begin
            tick();
            check({tag, "_q"}, q, 8'h0A);
            check({tag, "_training"}, training, 1'b1);
        end
        tick();
        check({tag, "_idle_q"}, q, 8'hFF);
        check({tag, "_link_up"}, link_up, 1'b1);
        check({tag, "_training_off"}, training, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        locked_in = 1'b0;
        retrain   = 1'b0;
        s_data    = 8'h00;
        s_valid   = 1'b0;
        tick();
        tick();
        check("rst_q", q, 8'hFF);
        check("rst_training", training, 1'b0);
        check("rst_link_up", link_up, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_level", fifo_level, 4'd0);
        #3 rst = 1'b0;
        tick();
        tick();
        check("nolock_q", q, 8'hFF);
        check("nolock_s_ready", s_ready, 1'b0);

        // 1: lock -> three idle cycles, 64 training words, then idle in RUN
        locked_in = 1'b1;
        check("lock_idle0", q, 8'hFF);
        tick();
        check("lock_idle1", q, 8'hFF);
        tick();
        check("lock_idle2", q, 8'hFF);
        check("lock_training_low", training, 1'b0);
        expect_burst("t1");

        // 2: streaming through an empty FIFO, one cycle latency
        s_valid = 1'b1;
        s_data  = 8'h11;
        check("t2_s_ready", s_ready, 1'b1);
        tick();
        check("t2_q0", q, 8'hFF);
        check("t2_lvl0", fifo_level, 4'd1);
        s_data = 8'h22;
        tick();
        check("t2_q1", q, 8'h11);
        check("t2_lvl1", fifo_level, 4'd1);
        s_data = 8'h33;
        tick();
        check("t2_q2", q, 8'h22);
        check("t2_lvl2", fifo_level, 4'd1);
        s_valid = 1'b0;
        tick();
        check("t2_q3", q, 8'h33);
        check("t2_lvl3", fifo_level, 4'd0);
        tick();
        check("t2_q4", q, 8'hFF);

        // 3: fill during TRAIN, drain back-to-back in RUN
        retrain = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h01;
        tick();
        retrain = 1'b0;
        s_data  = 8'h02;
        check("t3_train_start", training, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            s_data = 8'(i + 1);
        end
        check("t3_full_ready", s_ready, 1'b0);
        check("t3_full_level", fifo_level, 4'd8);
        check("t3_full_q", q, 8'h0A);
        for (int i = 9; i <= 64; i++) begin
            tick();
        end
        check("t3_last_train", training, 1'b1);
        check("t3_still_full", fifo_level, 4'd8);
        tick();
        check("t3_q1", q, 8'h01);
        check("t3_link", link_up, 1'b1);
        check("t3_lvl_after_pop", fifo_level, 4'd7);
        check("t3_ready_again", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        check("t3_q2", q, 8'h02);
        check("t3_lvl_push_pop", fifo_level, 4'd7);
        for (int v = 3; v <= 9; v++) begin
            tick();
            check("t3_drain", q, 8'(v));
        end
        tick();
        check("t3_idle", q, 8'hFF);
        check("t3_empty", fifo_level, 4'd0);

        // 4: retrain with two queued words; order preserved after the burst
        retrain = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA1;
        tick();
        retrain = 1'b0;
        s_data  = 8'hA2;
        check("t4_q_w1", q, 8'h0A);
        check("t4_train_w1", training, 1'b1);
        check("t4_lvl1", fifo_level, 4'd1);
        tick();
        s_valid = 1'b0;
        check("t4_q_w2", q, 8'h0A);
        check("t4_lvl2", fifo_level, 4'd2);
        for (int i = 3; i <= 64; i++) begin
            tick();
            check("t4_train_q", q, 8'h0A);
        end
        tick();
        check("t4_a1", q, 8'hA1);
        check("t4_link", link_up, 1'b1);
        tick();
        check("t4_a2", q, 8'hA2);
        tick();
        check("t4_idle", q, 8'hFF);

        // 5: lock loss with words queued flushes the FIFO; relock retrains
        retrain = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hC1;
        tick();
        retrain = 1'b0;
        s_data  = 8'hC2;
        tick();
        s_data = 8'hC3;
        tick();
        s_valid = 1'b0;
        check("t5_lvl3", fifo_level, 4'd3);
        for (int i = 4; i <= 64; i++) begin
            tick();
        end
        locked_in = 1'b0;
        tick();
        check("t5_c1", q, 8'hC1);
        tick();
        check("t5_c2", q, 8'hC2);
        check("t5_link_before", link_up, 1'b1);
        check("t5_lvl_before", fifo_level, 4'd1);
        tick();
        check("t5_q_idle", q, 8'hFF);
        check("t5_link_down", link_up, 1'b0);
        check("t5_s_ready", s_ready, 1'b0);
        check("t5_flushed", fifo_level, 4'd0);
        locked_in = 1'b1;
        tick();
        check("t5_relock0", q, 8'hFF);
        tick();
        check("t5_relock1", q, 8'hFF);
        check("t5_relock_training", training, 1'b0);
        expect_burst("t5");

        // 6: asynchronous reset mid-TRAIN
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("t6_in_train", training, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("t6_async_q", q, 8'hFF);
        check("t6_async_training", training, 1'b0);
        check("t6_async_link", link_up, 1'b0);
        #2 rst = 1'b0;
        tick();
        check("t6_post0", q, 8'hFF);
        tick();
        check("t6_post1", q, 8'hFF);
        expect_burst("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
